// File: rtl/fpu_pkg.sv
// Shared FPU definitions: RISC-V rounding-mode encodings, fflags bit positions
// and width-parametrised constant helpers for packed IEEE-754 formats.
package fpu_pkg;

    // Resolved rounding modes (DYN is replaced before reaching the FPU datapath)
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // fflags bit positions within {NV, DZ, OF, UF, NX}
    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_W  = 5;

    // All-ones exponent field, right-aligned in 64 bits
    function automatic logic [63:0] exp_all_ones(input int unsigned exp_w);
        return (64'(1) << exp_w) - 64'(1);
    endfunction

    // Largest finite magnitude {exp all-ones-minus-one, fraction all ones}, right-aligned
    function automatic logic [63:0] max_finite_mag(input int unsigned exp_w,
                                                   input int unsigned man_w);
        return (((64'(1) << exp_w) - 64'(2)) << man_w) | ((64'(1) << man_w) - 64'(1));
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational rounding decision shared by all FPU back-ends.
// Ports: sign/lsb/grs/rm describe the unrounded value, special marks an
// inf/NaN operand; inc_c is the increment bit, inexact_c the NX source and
// rm_err_c flags an unsupported rounding-mode encoding.
module fp_round_decide
    import fpu_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic [2:0] grs,
    input  logic [2:0] rm,
    input  logic       special,
    output logic       inc_c,
    output logic       inexact_c,
    output logic       rm_err_c
);

    logic guard;
    logic rnd;
    logic sticky;

    assign {guard, rnd, sticky} = grs;

    // Increment selection per rounding mode; inf/NaN operands are never rounded
    always_comb begin
        inc_c     = 1'b0;
        rm_err_c  = 1'b0;
        inexact_c = |grs;
        case (rm)
            RM_RNE:  inc_c = guard & (lsb | rnd | sticky);
            RM_RTZ:  inc_c = 1'b0;
            RM_RDN:  inc_c = sign & (|grs);
            RM_RUP:  inc_c = ~sign & (|grs);
            RM_RMM:  inc_c = guard;
            default: rm_err_c = 1'b1;
        endcase
        if (special) begin
            inc_c     = 1'b0;
            inexact_c = 1'b0;
        end
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding and packing pipeline with valid/ready flow
// control and synchronous flush.
// Ports: clk_i/reset_i (async active-high), flush_i kills both stages;
// in_valid_i/in_ready_o accept {sign_i, exp_i, man_i, grs_i, rm_i};
// out_valid_o/out_ready_i deliver result_o {sign, exp, fraction},
// flags_o {NV, DZ, OF, UF, NX} and rm_err_o.
module fp_round_pipe
    import fpu_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned FW    = 1 + EXP_W + MAN_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [MAN_W-1:0]  man_i,
    input  logic [2:0]        grs_i,
    input  logic [2:0]        rm_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [FW-1:0]     result_o,
    output logic [FLAG_W-1:0] flags_o,
    output logic              rm_err_o
);

    localparam int unsigned      SW       = EXP_W + MAN_W;
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(exp_all_ones(EXP_W));
    localparam logic [SW-1:0]    MAX_MAG  = SW'(max_finite_mag(EXP_W, MAN_W));
    localparam logic [SW-1:0]    INF_MAG  = {EXP_ONES, {MAN_W{1'b0}}};

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_load;
    logic             s2_load;
    logic             in_accept;

    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W-1:0] s1_man;
    logic [2:0]       s1_rm;
    logic             s1_inc;
    logic             s1_inexact;
    logic             s1_rm_err;
    logic             s1_special;

    logic             in_special;
    logic             dec_inc;
    logic             dec_inexact;
    logic             dec_rm_err;

    logic [SW-1:0]     sum_c;
    logic [EXP_W-1:0]  sum_exp_c;
    logic              ovf_c;
    logic [SW-1:0]     mag_c;
    logic [FLAG_W-1:0] flags_c;

    // Flow control: a stage loads when empty or when its contents move on
    assign s2_load     = ~s2_valid | out_ready_i;
    assign s1_load     = ~s1_valid | s2_load;
    assign in_ready_o  = s1_load & ~flush_i;
    assign in_accept   = in_valid_i & in_ready_o;
    assign out_valid_o = s2_valid;

    assign in_special = (exp_i == EXP_ONES);

    fp_round_decide u_decide (
        .sign      (sign_i),
        .lsb       (man_i[0]),
        .grs       (grs_i),
        .rm        (rm_i),
        .special   (in_special),
        .inc_c     (dec_inc),
        .inexact_c (dec_inexact),
        .rm_err_c  (dec_rm_err)
    );

    // Stage 1 payload capture
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_man     <= '0;
            s1_rm      <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_rm_err  <= 1'b0;
            s1_special <= 1'b0;
        end else if (in_accept) begin
            s1_sign    <= sign_i;
            s1_exp     <= exp_i;
            s1_man     <= man_i;
            s1_rm      <= rm_i;
            s1_inc     <= dec_inc;
            s1_inexact <= dec_inexact;
            s1_rm_err  <= dec_rm_err;
            s1_special <= in_special;
        end
    end

    // Stage 2 round/pack: a fraction carry ripples straight into the exponent
    always_comb begin
        sum_c     = {s1_exp, s1_man} + SW'(s1_inc);
        sum_exp_c = sum_c[SW-1:MAN_W];
        ovf_c     = ~s1_special & (sum_exp_c == EXP_ONES);
        mag_c     = sum_c;
        flags_c   = '0;
        if (ovf_c) begin
            case (s1_rm)
                RM_RTZ:  mag_c = MAX_MAG;
                RM_RDN:  mag_c = s1_sign ? INF_MAG : MAX_MAG;
                RM_RUP:  mag_c = s1_sign ? MAX_MAG : INF_MAG;
                default: mag_c = INF_MAG;
            endcase
            flags_c[FLAG_OF] = 1'b1;
            flags_c[FLAG_NX] = 1'b1;
        end else begin
            flags_c[FLAG_NX] = s1_inexact;
            // Tininess after rounding: still subnormal once the increment is applied
            flags_c[FLAG_UF] = s1_inexact & (sum_exp_c == '0);
        end
    end

    // Valid tracking and registered outputs; flush overrides every handshake
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
            rm_err_o <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid_i;
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
            end
            if (s2_load && s1_valid) begin
                result_o <= {s1_sign, mag_c};
                flags_o  <= flags_c;
                rm_err_o <= s1_rm_err;
            end
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// Self-checking bench for fp_round_pipe (single precision configuration).
module tb_fp_round_pipe;
    import fpu_pkg::*;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned FW    = 1 + EXP_W + MAN_W;

    logic              clk_i;
    logic              reset_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              sign_i;
    logic [EXP_W-1:0]  exp_i;
    logic [MAN_W-1:0]  man_i;
    logic [2:0]        grs_i;
    logic [2:0]        rm_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [FW-1:0]     result_o;
    logic [FLAG_W-1:0] flags_o;
    logic              rm_err_o;

    int checks;
    int errors;

    // Scoreboard entries: {rm_err, flags, result}
    logic [37:0] sb_q[$];

    typedef struct {
        logic        sign;
        logic [7:0]  ex;
        logic [22:0] man;
        logic [2:0]  grs;
        logic [2:0]  rm;
        logic [37:0] exp_out;
    } vec_t;

    fp_round_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sign_i      (sign_i),
        .exp_i       (exp_i),
        .man_i       (man_i),
        .grs_i       (grs_i),
        .rm_i        (rm_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .flags_o     (flags_o),
        .rm_err_o    (rm_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [22:0] m,
                                input logic [2:0] g, input logic [2:0] r,
                                input logic [31:0] res, input logic [4:0] fl, input logic err);
        vec_t v;
        v.sign    = s;
        v.ex      = e;
        v.man     = m;
        v.grs     = g;
        v.rm      = r;
        v.exp_out = {err, fl, res};
        return v;
    endfunction

    // Reference rounding of one single-precision operand
    function automatic logic [37:0] model(input logic s, input logic [7:0] e, input logic [22:0] m,
                                          input logic [2:0] g, input logic [2:0] r);
        logic        up;
        logic        err;
        logic        nx;
        logic [31:0] mag;
        logic [4:0]  fl;
        logic [31:0] res;
        err = (r > 3'd4);
        nx  = (g != 3'b000);
        if (e == 8'hFF) return {err, 5'b00000, s, e, m};
        case (r)
            3'd0:    up = g[2] && (g[1] || g[0] || m[0]);
            3'd2:    up = s && nx;
            3'd3:    up = !s && nx;
            3'd4:    up = g[2];
            default: up = 1'b0;
        endcase
        mag = {1'b0, e, m} + 32'(up);
        fl  = 5'b00000;
        fl[0] = nx;
        if (mag[30:23] == 8'hFF) begin
            // Only modes rounding away from zero can increment into overflow
            fl[2] = 1'b1;
            fl[0] = 1'b1;
            res   = {s, 8'hFF, 23'h0};
        end else begin
            res = {s, mag[30:0]};
            if (mag[30:23] == 8'h00 && nx) fl[1] = 1'b1;
        end
        return {err, fl, res};
    endfunction

    // Present one operand and hold it until accepted; returns on the negedge after acceptance
    task automatic drive_op(input logic s, input logic [7:0] e, input logic [22:0] m,
                            input logic [2:0] g, input logic [2:0] r);
        bit done = 1'b0;
        sign_i     = s;
        exp_i      = e;
        man_i      = m;
        grs_i      = g;
        rm_i       = r;
        in_valid_i = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (in_ready_o) done = 1'b1;
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL accept_timeout: in_ready_o stayed low for 40 cycles");
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || result_o !== 32'h0 || flags_o !== 5'h0 || rm_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b result=%h flags=%b rm_err=%b, want all zero",
                     out_valid_o, result_o, flags_o, rm_err_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_rounding();
        vec_t        v[$];
        logic [37:0] want;
        logic [37:0] got;
        v.push_back(mk(0, 8'h7F, 23'h000001, 3'b100, RM_RNE, 32'h3F800002, 5'h01, 0));
        v.push_back(mk(0, 8'h7F, 23'h000000, 3'b100, RM_RNE, 32'h3F800000, 5'h01, 0));
        v.push_back(mk(0, 8'h7F, 23'h000000, 3'b000, RM_RNE, 32'h3F800000, 5'h00, 0));
        v.push_back(mk(0, 8'h7F, 23'h000000, 3'b101, RM_RNE, 32'h3F800001, 5'h01, 0));
        v.push_back(mk(0, 8'h7F, 23'h7FFFFF, 3'b110, RM_RNE, 32'h40000000, 5'h01, 0));
        v.push_back(mk(0, 8'h7F, 23'h7FFFFF, 3'b110, RM_RTZ, 32'h3FFFFFFF, 5'h01, 0));
        v.push_back(mk(0, 8'hFE, 23'h7FFFFF, 3'b100, RM_RNE, 32'h7F800000, 5'h05, 0));
        v.push_back(mk(0, 8'hFE, 23'h7FFFFF, 3'b100, RM_RTZ, 32'h7F7FFFFF, 5'h01, 0));
        // Negative value under RUP is never incremented, so no overflow is raised
        v.push_back(mk(1, 8'hFE, 23'h7FFFFF, 3'b100, RM_RUP, 32'hFF7FFFFF, 5'h01, 0));
        v.push_back(mk(1, 8'hFE, 23'h7FFFFF, 3'b010, RM_RDN, 32'hFF800000, 5'h05, 0));
        v.push_back(mk(0, 8'hFE, 23'h7FFFFF, 3'b001, RM_RUP, 32'h7F800000, 5'h05, 0));
        v.push_back(mk(0, 8'hFE, 23'h7FFFFF, 3'b100, RM_RMM, 32'h7F800000, 5'h05, 0));
        v.push_back(mk(1, 8'h80, 23'h000000, 3'b001, RM_RDN, 32'hC0000001, 5'h01, 0));
        v.push_back(mk(1, 8'h80, 23'h000000, 3'b001, RM_RUP, 32'hC0000000, 5'h01, 0));
        v.push_back(mk(1, 8'h80, 23'h000000, 3'b001, 3'b101, 32'hC0000000, 5'h01, 1));
        v.push_back(mk(0, 8'h7F, 23'h000000, 3'b100, 3'b111, 32'h3F800000, 5'h01, 1));
        v.push_back(mk(0, 8'h7F, 23'h000000, 3'b100, RM_RMM, 32'h3F800001, 5'h01, 0));
        v.push_back(mk(0, 8'h00, 23'h000000, 3'b001, RM_RUP, 32'h00000001, 5'h03, 0));
        v.push_back(mk(0, 8'h00, 23'h7FFFFF, 3'b100, RM_RNE, 32'h00800000, 5'h01, 0));
        v.push_back(mk(0, 8'hFF, 23'h400000, 3'b111, RM_RNE, 32'h7FC00000, 5'h00, 0));
        out_ready_i = 1'b1;
        foreach (v[i]) begin
            sb_q.push_back(v[i].exp_out);
            drive_op(v[i].sign, v[i].ex, v[i].man, v[i].grs, v[i].rm);
            for (int n = 0; n < 10 && !out_valid_o; n++) @(negedge clk_i);
            want = sb_q.pop_front();
            got  = {rm_err_o, flags_o, result_o};
            checks++;
            if (out_valid_o !== 1'b1 || got !== want) begin
                errors++;
                $display("FAIL round[%0d]: valid=%b rm_err=%b flags=%b result=%h, want rm_err=%b flags=%b result=%h",
                         i, out_valid_o, got[37], got[36:32], got[31:0], want[37], want[36:32], want[31:0]);
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    logic        s;
                    logic [7:0]  e;
                    logic [22:0] m;
                    logic [2:0]  g;
                    logic [2:0]  r;
                    s = 1'($urandom);
                    case ($urandom_range(0, 4))
                        0:       e = 8'h7F;
                        1:       e = 8'hFE;
                        2:       e = 8'h00;
                        3:       e = 8'hFF;
                        default: e = 8'($urandom_range(1, 253));
                    endcase
                    m = 23'($urandom);
                    if (i == 0) m = 23'h7FFFFF;
                    g = 3'($urandom_range(0, 7));
                    r = 3'($urandom_range(0, 7));
                    sb_q.push_back(model(s, e, m, g, r));
                    drive_op(s, e, m, g, r);
                end
            end
            begin
                logic [37:0] want;
                int          got_n;
                int          t;
                t = 0;
                while (!out_valid_o && t < 20) begin
                    @(negedge clk_i);
                    t++;
                end
                want = (sb_q.size() > 0) ? sb_q.pop_front() : 38'h0;
                checks++;
                if (out_valid_o !== 1'b1 || {rm_err_o, flags_o, result_o} !== want) begin
                    errors++;
                    $display("FAIL b2b_first: valid=%b got=%h want=%h", out_valid_o,
                             {rm_err_o, flags_o, result_o}, want);
                end
                @(negedge clk_i);
                out_ready_i = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    #1;
                    want = (sb_q.size() > 0) ? sb_q[0] : 38'h0;
                    checks++;
                    if (out_valid_o !== 1'b1 || {rm_err_o, flags_o, result_o} !== want) begin
                        errors++;
                        $display("FAIL b2b_hold[%0d]: valid=%b got=%h want=%h", k, out_valid_o,
                                 {rm_err_o, flags_o, result_o}, want);
                    end
                    if (k >= 1) begin
                        checks++;
                        if (in_ready_o !== 1'b0) begin
                            errors++;
                            $display("FAIL b2b_in_ready[%0d]: in_ready_o=%b want 0", k, in_ready_o);
                        end
                    end
                    @(negedge clk_i);
                end
                out_ready_i = 1'b1;
                got_n = 1;
                t     = 0;
                while (got_n < 5 && t < 30) begin
                    if (out_valid_o) begin
                        want = (sb_q.size() > 0) ? sb_q.pop_front() : 38'h0;
                        checks++;
                        if ({rm_err_o, flags_o, result_o} !== want) begin
                            errors++;
                            $display("FAIL b2b_out[%0d]: got=%h want=%h", got_n,
                                     {rm_err_o, flags_o, result_o}, want);
                        end
                        got_n++;
                    end
                    @(negedge clk_i);
                    t++;
                end
                if (got_n < 5) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_timeout: %0d of 5 results seen", got_n);
                end
            end
        join
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b pending=%0d, want 0 and 0", out_valid_o, sb_q.size());
        end
    endtask

    task automatic test_reset_flush();
        logic [37:0] want;
        out_ready_i = 1'b0;
        drive_op(0, 8'h7F, 23'h000001, 3'b100, RM_RNE);
        drive_op(0, 8'h7F, 23'h000002, 3'b100, RM_RNE);
        checks++;
        if (out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL fill_valid: out_valid_o=%b want 1", out_valid_o);
        end
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if (out_valid_o !== 1'b0 || result_o !== 32'h0 || flags_o !== 5'h0 || rm_err_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b result=%h flags=%b rm_err=%b, want all zero",
                     out_valid_o, result_o, flags_o, rm_err_o);
        end
        @(negedge clk_i);
        reset_i     = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);

        drive_op(0, 8'h7F, 23'h000003, 3'b100, RM_RNE);
        sign_i     = 1'b0;
        exp_i      = 8'h7F;
        man_i      = 23'h000004;
        grs_i      = 3'b000;
        rm_i       = RM_RNE;
        in_valid_i = 1'b1;
        flush_i    = 1'b1;
        #1;
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: in_ready_o=%b want 0", in_ready_o);
        end
        @(negedge clk_i);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_out_valid: out_valid_o=%b want 0", out_valid_o);
        end
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: out_valid_o=%b want 0", out_valid_o);
        end

        sb_q.push_back({1'b0, 5'h01, 32'h3F800002});
        drive_op(0, 8'h7F, 23'h000001, 3'b100, RM_RNE);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: out_valid_o=%b one cycle after accept, want 0", out_valid_o);
        end
        @(negedge clk_i);
        want = sb_q.pop_front();
        checks++;
        if (out_valid_o !== 1'b1 || {rm_err_o, flags_o, result_o} !== want) begin
            errors++;
            $display("FAIL lat_two: valid=%b got=%h want valid=1 %h", out_valid_o,
                     {rm_err_o, flags_o, result_o}, want);
        end
        @(negedge clk_i);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_i     = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        sign_i      = 1'b0;
        exp_i       = '0;
        man_i       = '0;
        grs_i       = '0;
        rm_i        = '0;
        test_reset();
        test_rounding();
        test_back_to_back();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
